// File: rtl/mem_port_arbiter.sv
// Shares one in-order memory port between fetch (id 0) and load/store (id 1).
// Round-robin arbitration with request lock, in-order ID FIFO for response routing, fetch flush.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         f_req_valid,
  output logic                         f_req_ready,
  input  logic [ADDR_W-1:0]            f_req_addr,
  input  logic                         f_flush,
  output logic                         f_rsp_valid,
  input  logic                         f_rsp_ready,
  output logic [DATA_W-1:0]            f_rsp_data,
  input  logic                         d_req_valid,
  output logic                         d_req_ready,
  input  logic [ADDR_W-1:0]            d_req_addr,
  input  logic                         d_req_we,
  input  logic [DATA_W-1:0]            d_req_wdata,
  output logic                         d_rsp_valid,
  input  logic                         d_rsp_ready,
  output logic [DATA_W-1:0]            d_rsp_data,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [ADDR_W-1:0]            m_req_addr,
  output logic                         m_req_we,
  output logic [DATA_W-1:0]            m_req_wdata,
  input  logic                         m_rsp_valid,
  output logic                         m_rsp_ready,
  input  logic [DATA_W-1:0]            m_rsp_data,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         proto_err
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTST-1:0] id_q, id_d;
  logic [MAX_OUTST-1:0] kill_q, kill_d;
  logic                 lock_q, lock_d;
  logic                 lock_id_q, lock_id_d;
  logic                 rr_last_q, rr_last_d;
  logic                 proto_err_q, proto_err_d;

  logic sel, full, empty, push, pop, head_id, head_kill;

  always_comb begin
    full  = (count_q == CNT_W'(MAX_OUTST));
    empty = (count_q == '0);

    if (lock_q)                          sel = lock_id_q;
    else if (f_req_valid && d_req_valid) sel = ~rr_last_q;
    else                                 sel = d_req_valid;

    m_req_valid = !full && (sel ? d_req_valid : f_req_valid);
    m_req_addr  = sel ? d_req_addr : f_req_addr;
    m_req_we    = sel & d_req_we;
    m_req_wdata = sel ? d_req_wdata : '0;
    push        = m_req_valid && m_req_ready;
    f_req_ready = push && !sel;
    d_req_ready = push && sel;

    head_id     = id_q[rd_ptr_q];
    head_kill   = kill_q[rd_ptr_q];
    f_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    m_rsp_ready = 1'b0;
    if (!empty) begin
      if (head_kill) begin
        m_rsp_ready = 1'b1;
      end else if (!head_id) begin
        f_rsp_valid = m_rsp_valid;
        m_rsp_ready = f_rsp_ready;
      end else begin
        d_rsp_valid = m_rsp_valid;
        m_rsp_ready = d_rsp_ready;
      end
    end
    pop        = m_rsp_valid && m_rsp_ready;
    f_rsp_data = m_rsp_data;
    d_rsp_data = m_rsp_data;
    outst_cnt  = count_q;
    proto_err  = proto_err_q;
  end

  always_comb begin
    id_d        = id_q;
    kill_d      = kill_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rr_last_d   = rr_last_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    proto_err_d = proto_err_q | (m_rsp_valid && empty);

    // Killing stale (unoccupied) fetch slots is harmless: a push rewrites kill
    if (f_flush) kill_d = kill_q | ~id_q;
    if (push) begin
      id_d[wr_ptr_q]   = sel;
      kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      rr_last_d        = sel;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (m_req_valid && !m_req_ready) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end else if (push) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      id_q        <= '0;
      kill_q      <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      rr_last_q   <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      id_q        <= id_d;
      kill_q      <= kill_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      rr_last_q   <= rr_last_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, then random traffic against a queue-based model.
module tb_mem_port_arbiter;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset;
  logic f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_ready;
  logic [31:0] f_req_addr, f_rsp_data;
  logic d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic m_req_valid, m_req_ready, m_req_we, m_rsp_valid, m_rsp_ready;
  logic [31:0] m_req_addr, m_req_wdata, m_rsp_data;
  logic [2:0] outst_cnt;
  logic proto_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MO)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr), .f_flush(f_flush),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_req_wdata(m_req_wdata), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .outst_cnt(outst_cnt), .proto_err(proto_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic rst, fv; logic [31:0] fa; logic dv; logic [31:0] da; logic dwe; logic [31:0] dwd;
    logic mrdy, rspv; logic [31:0] rspd; logic frr, drr, fl;
    logic e_mv; logic [31:0] e_ma; logic e_we; logic [31:0] e_wd;
    logic e_frdy, e_drdy, e_frv, e_drv, e_mrr; int e_cnt; logic e_perr;
  } vec_t;

  function automatic vec_t v(input logic rst, fv, input logic [31:0] fa, input logic dv,
                             input logic [31:0] da, input logic dwe, input logic [31:0] dwd,
                             input logic mrdy, rspv, input logic [31:0] rspd, input logic frr, drr, fl,
                             input logic e_mv, input logic [31:0] e_ma, input logic e_we,
                             input logic [31:0] e_wd, input logic e_frdy, e_drdy, e_frv, e_drv, e_mrr,
                             input int e_cnt, input logic e_perr);
    vec_t r;
    r.rst = rst; r.fv = fv; r.fa = fa; r.dv = dv; r.da = da; r.dwe = dwe; r.dwd = dwd;
    r.mrdy = mrdy; r.rspv = rspv; r.rspd = rspd; r.frr = frr; r.drr = drr; r.fl = fl;
    r.e_mv = e_mv; r.e_ma = e_ma; r.e_we = e_we; r.e_wd = e_wd; r.e_frdy = e_frdy; r.e_drdy = e_drdy;
    r.e_frv = e_frv; r.e_drv = e_drv; r.e_mrr = e_mrr; r.e_cnt = e_cnt; r.e_perr = e_perr;
    return r;
  endfunction

  // Reference model: queue of outstanding owners plus round-robin/lock bookkeeping.
  typedef struct { logic id; logic kill; } ent_t;
  ent_t mq[$];
  logic m_rr_last, m_lock, m_lock_id, m_perr;

  task automatic model_reset();
    mq.delete();
    m_rr_last = 1'b1; m_lock = 1'b0; m_lock_id = 1'b0; m_perr = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    logic f_pend, d_pend;
    logic g, e_mv, hs, e_frv, e_drv, e_mrr, pop;
    string tag;

    reset = 1'b1;
    f_req_valid = 0; f_req_addr = 0; f_flush = 0; f_rsp_ready = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_rsp_ready = 0;
    m_req_ready = 0; m_rsp_valid = 0; m_rsp_data = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // rst fv fa dv da dwe dwd mrdy rspv rspd frr drr fl | mv ma we wd frdy drdy frv drv mrr cnt perr
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h0,0,0,0,0,1,0,0,0,0,0,      1,'h0,0,0,1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'hDEAD,1,0,0,   0,0,0,0,0,0,1,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h100,1,'h200,0,0,1,0,0,0,0,0, 1,'h100,0,0,1,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h104,1,'h200,0,0,1,0,0,0,0,0, 1,'h200,0,0,0,1,0,0,0,1,0));
    tbl.push_back(v(0,1,'h104,1,'h204,0,0,1,0,0,0,0,0, 1,'h104,0,0,1,0,0,0,0,2,0));
    tbl.push_back(v(0,1,'h108,1,'h204,0,0,1,0,0,0,0,0, 1,'h204,0,0,0,1,0,0,0,3,0));
    tbl.push_back(v(0,1,'h108,0,0,0,0,1,1,'h11,1,1,0,  0,0,0,0,0,0,1,0,1,4,0));
    tbl.push_back(v(0,1,'h108,0,0,0,0,1,1,'h22,1,1,0,  1,'h108,0,0,1,0,0,1,1,3,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h33,1,1,0,      0,0,0,0,0,0,1,0,1,3,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h44,1,1,0,      0,0,0,0,0,0,0,1,1,2,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h55,0,1,0,      0,0,0,0,0,0,1,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h55,1,1,0,      0,0,0,0,0,0,1,0,1,1,0));
    tbl.push_back(v(0,0,0,1,'h280,0,0,1,0,0,0,0,0,     1,'h280,0,0,0,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h66,0,1,0,      0,0,0,0,0,0,0,1,1,1,0));
    tbl.push_back(v(0,0,0,1,'h300,1,'hAA,0,0,0,0,0,0,  1,'h300,1,'hAA,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h400,1,'h300,1,'hAA,0,0,0,0,0,0, 1,'h300,1,'hAA,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h400,1,'h300,1,'hAA,0,0,0,0,0,0, 1,'h300,1,'hAA,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h400,1,'h300,1,'hAA,1,0,0,0,0,0, 1,'h300,1,'hAA,0,1,0,0,0,0,0));
    tbl.push_back(v(0,1,'h400,0,'h0,1,'hAA,1,0,0,0,0,0,   1,'h400,0,0,1,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h77,0,1,0,      0,0,0,0,0,0,0,1,1,2,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h88,1,0,0,      0,0,0,0,0,0,1,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h500,0,0,0,0,1,0,0,0,0,0,     1,'h500,0,0,1,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h504,0,0,0,0,1,0,0,0,0,0,     1,'h504,0,0,1,0,0,0,0,1,0));
    tbl.push_back(v(0,1,'h508,0,0,0,0,1,0,0,0,0,0,     1,'h508,0,0,1,0,0,0,0,2,0));
    tbl.push_back(v(0,0,0,1,'h600,0,0,1,0,0,0,0,1,     1,'h600,0,0,0,1,0,0,0,3,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h1,0,0,0,       0,0,0,0,0,0,0,0,1,4,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h2,0,0,0,       0,0,0,0,0,0,0,0,1,3,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h3,0,0,0,       0,0,0,0,0,0,0,0,1,2,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h99,0,1,0,      0,0,0,0,0,0,0,1,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h5,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h700,0,0,0,0,1,0,0,0,0,0,     1,'h700,0,0,1,0,0,0,0,0,1));
    tbl.push_back(v(0,1,'h704,1,'h800,0,0,1,0,0,0,0,0, 1,'h800,0,0,0,1,0,0,0,1,1));
    tbl.push_back(v(0,1,'h704,0,0,0,0,0,0,0,0,0,0,     1,'h704,0,0,0,0,0,0,0,2,1));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h900,1,'hA00,0,0,0,0,0,0,0,0, 1,'h900,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,'h900,1,'hA00,0,0,1,0,0,0,0,0, 1,'h900,0,0,1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,'hA00,0,0,1,1,'hBEEF,1,0,0, 1,'hA00,0,0,0,1,1,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,'h1234,0,1,0,    0,0,0,0,0,0,0,1,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      f_req_valid = tbl[i].fv; f_req_addr = tbl[i].fa;
      d_req_valid = tbl[i].dv; d_req_addr = tbl[i].da; d_req_we = tbl[i].dwe; d_req_wdata = tbl[i].dwd;
      m_req_ready = tbl[i].mrdy; m_rsp_valid = tbl[i].rspv; m_rsp_data = tbl[i].rspd;
      f_rsp_ready = tbl[i].frr; d_rsp_ready = tbl[i].drr; f_flush = tbl[i].fl;
      if (!tbl[i].rst) begin
        #1;
        tag = $sformatf("vec%0d", i);
        chk({tag, " m_req_valid"}, m_req_valid, tbl[i].e_mv);
        if (tbl[i].e_mv) begin
          chk({tag, " m_req_addr"}, m_req_addr, tbl[i].e_ma);
          chk({tag, " m_req_we"}, m_req_we, tbl[i].e_we);
          chk({tag, " m_req_wdata"}, m_req_wdata, tbl[i].e_wd);
        end
        chk({tag, " f_req_ready"}, f_req_ready, tbl[i].e_frdy);
        chk({tag, " d_req_ready"}, d_req_ready, tbl[i].e_drdy);
        chk({tag, " f_rsp_valid"}, f_rsp_valid, tbl[i].e_frv);
        chk({tag, " d_rsp_valid"}, d_rsp_valid, tbl[i].e_drv);
        chk({tag, " m_rsp_ready"}, m_rsp_ready, tbl[i].e_mrr);
        chk({tag, " outst_cnt"}, outst_cnt, tbl[i].e_cnt);
        chk({tag, " proto_err"}, proto_err, tbl[i].e_perr);
        if (tbl[i].e_frv) chk({tag, " f_rsp_data"}, f_rsp_data, tbl[i].rspd);
        if (tbl[i].e_drv) chk({tag, " d_rsp_data"}, d_rsp_data, tbl[i].rspd);
      end
      @(posedge clk);
      #1 reset = 1'b0;
    end

    // Random traffic; requesters hold valid and payload until accepted.
    reset = 1'b1;
    f_req_valid = 0; d_req_valid = 0; m_rsp_valid = 0; f_flush = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    f_pend = 0; d_pend = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!f_pend && ($urandom % 3 == 0)) begin f_pend = 1; f_req_addr = $urandom; end
      if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1; d_req_addr = $urandom; d_req_we = $urandom % 2; d_req_wdata = $urandom;
      end
      f_req_valid = f_pend; d_req_valid = d_pend;
      m_req_ready = ($urandom % 4) != 0;
      m_rsp_valid = (mq.size() > 0) && ($urandom % 2 == 1);
      m_rsp_data = $urandom;
      f_rsp_ready = ($urandom % 4) != 0;
      d_rsp_ready = ($urandom % 4) != 0;
      f_flush = ($urandom % 16) == 0;
      #1;

      // Arbitration: a held request keeps the port; on a tie, serve whoever was not served last.
      if (m_lock) g = m_lock_id;
      else if (f_pend && d_pend) g = (m_rr_last == 1'b0);
      else g = d_pend;
      e_mv = (mq.size() < MO) && (g ? d_pend : f_pend);
      hs = e_mv && m_req_ready;
      e_frv = 0; e_drv = 0; e_mrr = 0;
      if (mq.size() > 0) begin
        if (mq[0].kill) e_mrr = 1;
        else if (mq[0].id == 0) begin e_frv = m_rsp_valid; e_mrr = f_rsp_ready; end
        else begin e_drv = m_rsp_valid; e_mrr = d_rsp_ready; end
      end
      pop = m_rsp_valid && e_mrr;

      tag = $sformatf("rnd%0d", cyc);
      chk({tag, " m_req_valid"}, m_req_valid, e_mv);
      if (e_mv) begin
        chk({tag, " m_req_addr"}, m_req_addr, g ? d_req_addr : f_req_addr);
        chk({tag, " m_req_we"}, m_req_we, g && d_req_we);
        chk({tag, " m_req_wdata"}, m_req_wdata, g ? d_req_wdata : 32'h0);
      end
      chk({tag, " f_req_ready"}, f_req_ready, hs && !g);
      chk({tag, " d_req_ready"}, d_req_ready, hs && g);
      chk({tag, " f_rsp_valid"}, f_rsp_valid, e_frv);
      chk({tag, " d_rsp_valid"}, d_rsp_valid, e_drv);
      chk({tag, " m_rsp_ready"}, m_rsp_ready, e_mrr);
      chk({tag, " outst_cnt"}, outst_cnt, mq.size());
      chk({tag, " proto_err"}, proto_err, m_perr);
      if (e_frv) chk({tag, " f_rsp_data"}, f_rsp_data, m_rsp_data);
      if (e_drv) chk({tag, " d_rsp_data"}, d_rsp_data, m_rsp_data);

      @(posedge clk);
      if (m_rsp_valid && mq.size() == 0) m_perr = 1;
      if (f_flush) foreach (mq[k]) if (mq[k].id == 0) mq[k].kill = 1;
      if (pop) void'(mq.pop_front());
      if (hs) begin
        mq.push_back('{id: g, kill: 1'b0});
        m_rr_last = g;
        if (g) d_pend = 0; else f_pend = 0;
      end
      if (e_mv && !m_req_ready) begin m_lock = 1; m_lock_id = g; end
      else if (hs) m_lock = 0;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one in-order memory port between two requesters: the fetch stage (requester 0, imem side) and the load/store stage (requester 1, dmem side).
- Arbitrates requests round-robin and tags each accepted request with its requester ID in an in-order ID FIFO.
- Routes each memory response back to its owner.
- Supports a fetch flush: after a taken branch, responses to already-issued fetches are discarded.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_OUTST, 4, max requests issued but not yet answered; power of 2, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted
- f_req_addr  in  ADDR_W  fetch address
- f_flush  in  1  kill all outstanding fetch responses
- f_rsp_valid  out  1  fetch response valid
- f_rsp_ready  in  1  fetch can take response
- f_rsp_data  out  DATA_W  fetch response data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_req_addr  in  ADDR_W  data address
- d_req_we  in  1  1 = store
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  data response valid (load data or store ack)
- d_rsp_ready  in  1  data can take response
- d_rsp_data  out  DATA_W  data response data
- m_req_valid  out  1  memory request valid
- m_req_ready  in  1  memory accepts request
- m_req_addr  out  ADDR_W  memory address
- m_req_we  out  1  memory write enable
- m_req_wdata  out  DATA_W  memory write data
- m_rsp_valid  in  1  memory response valid (one per request, in order)
- m_rsp_ready  out  1  response consumed
- m_rsp_data  in  DATA_W  memory response data
- outst_cnt  out  log2(MAX_OUTST)+1  current outstanding count
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all of the following are cleared.
  - count=0, FIFO pointers=0, lock=0, rr_last=1 (fetch wins the first tie), proto_err=0, all kill bits=0.
  - All *_valid and *_ready outputs read 0 while count=0 and no requests are pending.
- Reset mid-operation: outstanding entries are dropped. Any later m_rsp_valid with count=0 sets proto_err.
- Request path is combinational, zero latency. sel drives m_req_addr/we/wdata.
  - Fetch requests: m_req_we=0, m_req_wdata=0.
- full = (count==MAX_OUTST), using the registered count. A pop in the same cycle does not free a slot (no bypass).
  - When full: m_req_valid=0, f_req_ready=0, d_req_ready=0.
- Arbitration when lock=0 and not full:
  - If only one requester is valid, sel = that requester.
  - If both are valid, sel = the requester that is not rr_last.
  - m_req_valid = valid of sel.
- Lock:
  - If m_req_valid=1 and m_req_ready=0, set lock and hold lock_id=sel.
  - While locked, sel=lock_id regardless of the other requester. Lock clears on the handshake.
  - Requesters must hold valid and payload until ready.
- Handshake (m_req_valid & m_req_ready):
  - x_req_ready=1 only for sel.
  - Push {id=sel, kill=0} into the FIFO; count+1.
  - Update rr_last=sel.
- Response routing uses head = FIFO head.
  - head id=0, kill=0: f_rsp_valid=m_rsp_valid, m_rsp_ready=f_rsp_ready.
  - head id=1: d_rsp_valid=m_rsp_valid, m_rsp_ready=d_rsp_ready.
  - head kill=1: m_rsp_ready=1 and no rsp_valid (response silently discarded).
  - count=0: m_rsp_ready=0. If m_rsp_valid=1, set proto_err.
  - f_rsp_data = d_rsp_data = m_rsp_data.
- Pop on m_rsp_valid & m_rsp_ready; count-1. A push and a pop in the same cycle leave count unchanged.
- Flush: f_flush=1 sets kill on every valid FIFO entry with id=0 at that clock edge.
  - An entry pushed on the same edge is not killed.
  - A head response popped on the same edge is delivered normally (f_rsp_valid is not masked combinationally).
  - Data entries are never killed.
- FIFO pointers wrap modulo MAX_OUTST.
- proto_err clears only on reset.

Test Plan:
- Idle after reset, f_req_valid=1 addr 0x0, m_req_ready=1 -> same-cycle m_req_addr=0x0, f_req_ready=1, outst_cnt=1. A later m_rsp 0xDEAD -> f_rsp_valid=1, data 0xDEAD.
- Both requesters valid every cycle, m_req_ready=1 -> grants alternate F,D,F,D starting with F. The ID FIFO routes 4 in-order responses to F,D,F,D.
- d_req valid, m_req_ready=0 for 3 cycles while f_req also asserts -> m_req stays on D with stable addr/we/wdata. On ready, D is accepted and F is granted next cycle.
- 4 fetches issued with no responses -> outst_cnt=4, all req_ready=0. One response pops, with a new request in the same cycle -> the request is not accepted until the next cycle. Pointers wrap correctly over 10 requests.
- 3 fetches outstanding, pulse f_flush, then a data request -> 3 fetch responses consumed with f_rsp_valid=0, m_rsp_ready=1. The data response is delivered on d_rsp.
- m_rsp_valid=1 with count=0, then reset asserted with 2 outstanding -> proto_err=1 and stays set. After reset: outst_cnt=0, proto_err=0, rr_last=1.
